// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared encodings for the decode stage.
//   RF2_*   : rR2 source select (rk field or rd field)
//   RFWR_*  : write-register select (rd field or r1 for jal)
//   SEXT_*  : immediate extension modes
//   id_ctrl_t : registered control fields of the ID/EX bundle
package id_stage_pkg;

    localparam logic RF2_RD   = 1'b0;   // rR2 = inst[4:0]
    localparam logic RF2_RK   = 1'b1;   // rR2 = inst[14:10]
    localparam logic RFWR_N   = 1'b0;   // wR  = inst[4:0]
    localparam logic RFWR_JAL = 1'b1;   // wR  = r1 (link register)

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;

    typedef enum logic [2:0] {
        SEXT_SI12 = 3'd0,   // sext(inst[21:10])
        SEXT_UI12 = 3'd1,   // zext(inst[21:10])
        SEXT_SI16 = 3'd2,   // sext(inst[25:10]) << 2, branch offset
        SEXT_SI20 = 3'd3,   // inst[24:5] << 12, lu12i
        SEXT_SI26 = 3'd4,   // sext({inst[9:0], inst[25:10]}) << 2, b/bl
        SEXT_UI5  = 3'd5    // zext(inst[14:10]), shift amount
    } sext_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic        we;
    } id_ctrl_t;

endpackage

// File: rtl/id_fwd_sel.sv
// id_fwd_sel: operand resolution for one read port.
//   rr                         : register being read
//   fwd_we/fwd_wr/fwd_wd/fwd_load : producer stages, index 0 youngest
//   wb_we/wb_wr/wb_wd          : same-cycle writeback
//   rf_rd                      : register file value
//   data                       : resolved operand
//   is_load                    : winning producer holds a not-yet-valid load
module id_fwd_sel
    import id_stage_pkg::*;
#(
    parameter int FWD_N  = 2,
    parameter int DATA_W = 32
) (
    input  logic [4:0]                   rr,
    input  logic [FWD_N-1:0]             fwd_we,
    input  logic [FWD_N-1:0][4:0]        fwd_wr,
    input  logic [FWD_N-1:0][DATA_W-1:0] fwd_wd,
    input  logic [FWD_N-1:0]             fwd_load,
    input  logic                         wb_we,
    input  logic [4:0]                   wb_wr,
    input  logic [DATA_W-1:0]            wb_wd,
    input  logic [DATA_W-1:0]            rf_rd,
    output logic [DATA_W-1:0]            data,
    output logic                         is_load
);

    logic hit;

    always_comb begin
        data    = rf_rd;
        is_load = 1'b0;
        hit     = 1'b0;
        if (rr == REG_ZERO) begin
            data = '0;
        end else begin
            // Youngest producer wins; an older load hidden behind it never stalls.
            for (int i = 0; i < FWD_N; i++) begin
                if (!hit && fwd_we[i] && fwd_wr[i] == rr) begin
                    hit     = 1'b1;
                    data    = fwd_wd[i];
                    is_load = fwd_load[i];
                end
            end
            if (!hit && wb_we && wb_wr == rr) begin
                data = wb_wd;
            end
        end
    end

endmodule

// File: rtl/id_rf.sv
// id_rf: 32 x DATA_W register file, two async read ports, one write port.
//   clk, rst : clock, synchronous active-high reset (clears all entries)
//   we/wr/wd : write port; writes to r0 are dropped
//   rr1/rr2  : read addresses; rd1/rd2 read data
module id_rf
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        rr1,
    input  logic [4:0]        rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [31:0][DATA_W-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we && wr != REG_ZERO) begin
            regs[wr] <= wd;
        end
    end

    assign rd1 = regs[rr1];
    assign rd2 = regs[rr2];

endmodule

// File: rtl/id_sext.sv
// id_sext: immediate extraction and extension.
//   op   : extension mode (sext_op_e)
//   inst : instruction word
//   ext  : extended immediate, DATA_W wide
module id_sext
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [31:0]       inst,
    output logic [DATA_W-1:0] ext
);

    logic [31:0] e32;
    logic        unused_inst;

    assign unused_inst = ^inst[31:26];

    always_comb begin
        e32 = '0;
        case (op)
            SEXT_SI12: e32 = {{20{inst[21]}}, inst[21:10]};
            SEXT_UI12: e32 = {20'd0, inst[21:10]};
            SEXT_SI16: e32 = {{14{inst[25]}}, inst[25:10], 2'b00};
            SEXT_SI20: e32 = {inst[24:5], 12'd0};
            SEXT_SI26: e32 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
            SEXT_UI5:  e32 = {27'd0, inst[14:10]};
            default:   e32 = '0;
        endcase
    end

    // Zero-extended modes leave bit 31 clear, so replicating bit 31 is
    // correct for every mode when widening.
    generate
        if (DATA_W > 32) begin : g_wide
            assign ext = {{(DATA_W-32){e32[31]}}, e32};
        end else begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^e32;
            assign ext = e32[DATA_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode with forwarding, load-use stall and ID/EX reg.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : handshake from IF/ID
//   inst, pc, sext_op, rf2_sel, rf_wrsel, rf_we_in, use_r1, use_r2 : decode inputs
//   fwd_we/wR/wD/load     : FWD_N producer stages (index 0 youngest)
//   wb_we/wR/wD           : writeback, also the RF write port
//   flush                 : kill this stage and ID/EX
//   out_valid/out_ready   : handshake to EX
//   out_*                 : registered ID/EX bundle
module id_stage
    import id_stage_pkg::*;
#(
    parameter int FWD_N  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             inst,
    input  logic [31:0]             pc,
    input  logic [2:0]              sext_op,
    input  logic                    rf2_sel,
    input  logic                    rf_wrsel,
    input  logic                    rf_we_in,
    input  logic                    use_r1,
    input  logic                    use_r2,
    input  logic [FWD_N-1:0]        fwd_we,
    input  logic [5*FWD_N-1:0]      fwd_wR,
    input  logic [DATA_W*FWD_N-1:0] fwd_wD,
    input  logic [FWD_N-1:0]        fwd_load,
    input  logic                    wb_we,
    input  logic [4:0]              wb_wR,
    input  logic [DATA_W-1:0]       wb_wD,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [4:0]              out_rR1,
    output logic [4:0]              out_rR2,
    output logic [4:0]              out_wR,
    output logic [DATA_W-1:0]       out_rD1,
    output logic [DATA_W-1:0]       out_rD2,
    output logic [DATA_W-1:0]       out_ext,
    output logic                    out_we
);

    logic [1:0][4:0]              rr_a;
    logic [4:0]                   wr;
    logic [1:0][DATA_W-1:0]       rf_rd;
    logic [1:0][DATA_W-1:0]       op_rd;
    logic [1:0]                   op_ld;
    logic [FWD_N-1:0][4:0]        fwd_wr_a;
    logic [FWD_N-1:0][DATA_W-1:0] fwd_wd_a;
    logic [DATA_W-1:0]            ext;
    logic                         hazard, advance;
    id_ctrl_t                     ctrl_q;

    assign rr_a[0]  = inst[9:5];
    assign rr_a[1]  = (rf2_sel == RF2_RK) ? inst[14:10] : inst[4:0];
    assign wr       = (rf_wrsel == RFWR_N) ? inst[4:0] : REG_RA;
    assign fwd_wr_a = fwd_wR;
    assign fwd_wd_a = fwd_wD;

    id_rf #(.DATA_W(DATA_W)) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wr  (wb_wR),
        .wd  (wb_wD),
        .rr1 (rr_a[0]),
        .rr2 (rr_a[1]),
        .rd1 (rf_rd[0]),
        .rd2 (rf_rd[1])
    );

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            id_fwd_sel #(.FWD_N(FWD_N), .DATA_W(DATA_W)) u_sel (
                .rr       (rr_a[p]),
                .fwd_we   (fwd_we),
                .fwd_wr   (fwd_wr_a),
                .fwd_wd   (fwd_wd_a),
                .fwd_load (fwd_load),
                .wb_we    (wb_we),
                .wb_wr    (wb_wR),
                .wb_wd    (wb_wD),
                .rf_rd    (rf_rd[p]),
                .data     (op_rd[p]),
                .is_load  (op_ld[p])
            );
        end
    endgenerate

    id_sext #(.DATA_W(DATA_W)) u_sext (
        .op   (sext_op),
        .inst (inst),
        .ext  (ext)
    );

    assign hazard   = in_valid & ((use_r1 & op_ld[0]) | (use_r2 & op_ld[1]));
    assign advance  = !out_valid | out_ready;
    assign in_ready = !rst & !flush & !hazard & advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            out_rD1   <= '0;
            out_rD2   <= '0;
            out_ext   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            // in_ready already folds in hazard, so a stalled slot becomes a bubble.
            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                ctrl_q    <= '{pc: pc, rr1: rr_a[0], rr2: rr_a[1], wr: wr, we: rf_we_in};
                out_rD1   <= op_rd[0];
                out_rD2   <= op_rd[1];
                out_ext   <= ext;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_pc  = ctrl_q.pc;
    assign out_rR1 = ctrl_q.rr1;
    assign out_rR2 = ctrl_q.rr2;
    assign out_wR  = ctrl_q.wr;
    assign out_we  = ctrl_q.we;

endmodule
